// File: rtl/fsbm_pkg.sv
// Shared types for the full-search block-matching datapath.
// SAD width, tracker FSM states and the motion-vector component type.
package fsbm_pkg;

    localparam int SAD_W    = 12;
    localparam int MV_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef logic signed [MV_W_DEF-1:0] mv_t;

endpackage

// File: rtl/sad_pos_counter.sv
// Raster-order x/y candidate position counters, -SR..+SR per axis.
// x runs fastest; last_o marks the (+SR,+SR) corner.
module sad_pos_counter #(
    parameter int SR   = 7,
    parameter int MV_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic                   adv_i,
    output logic signed [MV_W-1:0] x_o,
    output logic signed [MV_W-1:0] y_o,
    output logic                   last_o
);

    localparam logic signed [MV_W-1:0] POS = MV_W'(SR);
    localparam logic signed [MV_W-1:0] NEG = -POS;

    logic signed [MV_W-1:0] x_q, x_d;
    logic signed [MV_W-1:0] y_q, y_d;

    // Next position: reload on start, step in raster order on each accept.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = NEG;
            y_d = NEG;
        end else if (adv_i) begin
            if (x_q == POS) begin
                x_d = NEG;
                y_d = y_q + MV_W'(1);
            end else begin
                x_d = x_q + MV_W'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == POS) && (y_q == POS);

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD over a (2*SR+1)^2 full search and its offset.
// Optional SAD_EARLY_TERM_EN: a zero SAD ends the search at once.
module sad_min_tracker
    import fsbm_pkg::*;
#(
    parameter int SR   = 7,
    parameter int MV_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sad_valid,
    input  logic [SAD_W-1:0]       sad,
    output logic                   busy,
    output logic                   done,
    output logic [SAD_W-1:0]       best_sad,
    output logic signed [MV_W-1:0] best_mvx,
    output logic signed [MV_W-1:0] best_mvy
);

    state_e                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   first_q;
    logic [SAD_W-1:0]       min_sad_q;
    logic signed [MV_W-1:0] min_x_q;
    logic signed [MV_W-1:0] min_y_q;
    logic [SAD_W-1:0]       best_sad_q;
    logic signed [MV_W-1:0] best_x_q;
    logic signed [MV_W-1:0] best_y_q;

    logic                   launch;
    logic                   accept;
    logic                   take;
    logic                   zero_hit;
    logic                   finish;
    logic                   pos_last;
    logic signed [MV_W-1:0] pos_x;
    logic signed [MV_W-1:0] pos_y;
    logic [SAD_W-1:0]       min_sad_d;
    logic signed [MV_W-1:0] min_x_d;
    logic signed [MV_W-1:0] min_y_d;

    assign launch = (state_q == IDLE) && start;
    assign accept = (state_q == SEARCH) && sad_valid;
    assign take   = accept && (first_q || (sad < min_sad_q));

`ifdef SAD_EARLY_TERM_EN
    assign zero_hit = accept && (sad == '0);
`else
    assign zero_hit = 1'b0;
`endif

    assign finish = (accept && pos_last) || zero_hit;

    sad_pos_counter #(
        .SR   (SR),
        .MV_W (MV_W)
    ) u_pos (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (launch),
        .adv_i  (accept),
        .x_o    (pos_x),
        .y_o    (pos_y),
        .last_o (pos_last)
    );

    // Running minimum including the candidate accepted this cycle.
    always_comb begin
        min_sad_d = min_sad_q;
        min_x_d   = min_x_q;
        min_y_d   = min_y_q;
        if (take) begin
            min_sad_d = sad;
            min_x_d   = pos_x;
            min_y_d   = pos_y;
        end
    end

    // Running-minimum registers; first accept loads unconditionally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q   <= 1'b0;
            min_sad_q <= '0;
            min_x_q   <= '0;
            min_y_q   <= '0;
        end else begin
            if (launch) begin
                first_q <= 1'b1;
            end else if (accept) begin
                first_q <= 1'b0;
            end
            min_sad_q <= min_sad_d;
            min_x_q   <= min_x_d;
            min_y_q   <= min_y_d;
        end
    end

    // Control FSM with registered busy/done and published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            best_sad_q <= '1;
            best_x_q   <= '0;
            best_y_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SEARCH;
                        busy_q  <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (finish) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        best_sad_q <= min_sad_d;
                        best_x_q   <= min_x_d;
                        best_y_q   <= min_y_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign best_sad = best_sad_q;
    assign best_mvx = best_x_q;
    assign best_mvy = best_y_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker (SR=2 and default SR=7 instances).
// Expected results are queued at stimulus time and checked on done.
module tb_sad_min_tracker;

    typedef struct {
        int sad;
        int x;
        int y;
        int cyc;
    } exp_t;

`ifdef SAD_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sad_valid;
    logic [11:0] sad;
    logic        busy;
    logic        done;
    logic [11:0] best_sad;
    logic [4:0]  best_mvx;
    logic [4:0]  best_mvy;

    logic        start7;
    logic        sad_valid7;
    logic [11:0] sad7;
    logic        busy7;
    logic        done7;
    logic [11:0] best_sad7;
    logic [4:0]  best_mvx7;
    logic [4:0]  best_mvy7;

    int   nchk  = 0;
    int   nfail = 0;
    int   cyc   = 0;
    int   vals[25];
    exp_t q2[$];
    exp_t q7[$];
    int   last_sad;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sad_min_tracker #(.SR(2), .MV_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sad_valid (sad_valid),
        .sad       (sad),
        .busy      (busy),
        .done      (done),
        .best_sad  (best_sad),
        .best_mvx  (best_mvx),
        .best_mvy  (best_mvy)
    );

    sad_min_tracker dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start7),
        .sad_valid (sad_valid7),
        .sad       (sad7),
        .busy      (busy7),
        .done      (done7),
        .best_sad  (best_sad7),
        .best_mvx  (best_mvx7),
        .best_mvy  (best_mvy7)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever a DUT publishes a result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q2.size() == 0) begin
                chk("sr2_unexpected_done", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("sr2_sad", int'(best_sad), e.sad);
                chk("sr2_mvx", int'($signed(best_mvx)), e.x);
                chk("sr2_mvy", int'($signed(best_mvy)), e.y);
                chk("sr2_done_cyc", cyc, e.cyc);
                chk("sr2_busy_at_done", int'(busy), 0);
            end
        end
        if (rst_n && done7) begin
            if (q7.size() == 0) begin
                chk("sr7_unexpected_done", 1, 0);
            end else begin
                e = q7.pop_front();
                chk("sr7_sad", int'(best_sad7), e.sad);
                chk("sr7_mvx", int'($signed(best_mvx7)), e.x);
                chk("sr7_mvy", int'($signed(best_mvy7)), e.y);
                chk("sr7_done_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SR=2 search over vals[]; junk=1 also pokes start/sad_valid
    // in IDLE, in the start cycle, mid-search and in DONE.
    task automatic run_search(input bit gaps, input bit junk);
        int   bs;
        int   bx;
        int   by;
        bit   first;
        bit   fin;
        exp_t e;
        if (junk) begin
            sad_valid = 1'b1;
            sad       = 12'd1;
            tick();
            tick();
            sad_valid = 1'b0;
            tick();
        end
        start = 1'b1;
        if (junk) begin
            sad_valid = 1'b1;
            sad       = 12'd0;
        end
        tick();
        start     = 1'b0;
        sad_valid = 1'b0;
        first     = 1'b1;
        bs = 0;
        bx = 0;
        by = 0;
        for (int k = 0; k < 25; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    sad_valid = 1'b0;
                    start     = 1'b0;
                    tick();
                    chk("busy_in_gap", int'(busy), 1);
                end
            end
            sad_valid = 1'b1;
            sad       = vals[k][11:0];
            start     = junk && (k == 5);
            if (first || vals[k] < bs) begin
                bs = vals[k];
                bx = (k % 5) - 2;
                by = (k / 5) - 2;
            end
            first = 1'b0;
            fin   = (k == 24) || (ET && vals[k] == 0);
            if (fin) begin
                e.sad = bs;
                e.x   = bx;
                e.y   = by;
                e.cyc = cyc + 1;
                q2.push_back(e);
                last_sad = bs;
            end
            tick();
            if (fin) break;
        end
        start     = 1'b0;
        sad_valid = 1'b0;
        if (junk) begin
            start     = 1'b1;
            sad_valid = 1'b1;
            sad       = 12'd0;
            tick();
            start     = 1'b0;
            sad_valid = 1'b0;
        end
        repeat (4) tick();
        chk("hold_best_sad", int'(best_sad), last_sad);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        exp_t e;
        rst_n      = 1'b0;
        start      = 1'b0;
        sad_valid  = 1'b0;
        sad        = '0;
        start7     = 1'b0;
        sad_valid7 = 1'b0;
        sad7       = '0;
        last_sad   = 0;
        #12;
        chk("rst_best_sad", int'(best_sad), 12'hFFF);
        chk("rst_mvx", int'(best_mvx), 0);
        chk("rst_mvy", int'(best_mvy), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        tick();

        // Descending SADs: last candidate wins, (+2,+2) sad 76.
        for (int k = 0; k < 25; k++) vals[k] = 100 - k;
        run_search(1'b0, 1'b0);
        chk("desc_const_sad", int'(best_sad), 76);
        chk("desc_const_mvx", int'($signed(best_mvx)), 2);
        chk("desc_const_mvy", int'($signed(best_mvy)), 2);

        // All ties: first candidate (-2,-2) kept.
        for (int k = 0; k < 25; k++) vals[k] = 50;
        run_search(1'b0, 1'b0);
        chk("tie_const_mvx", int'($signed(best_mvx)), -2);
        chk("tie_const_mvy", int'($signed(best_mvy)), -2);

        // Single minimum at centre with random valid gaps.
        for (int k = 0; k < 25; k++) vals[k] = (k == 12) ? 7 : 200;
        run_search(1'b1, 1'b0);
        chk("gap_const_mvx", int'($signed(best_mvx)), 0);

        // Zero SAD at candidate 3: (+1,-2).
        for (int k = 0; k < 25; k++) vals[k] = (k == 3) ? 0 : 200;
        run_search(1'b0, 1'b0);
        chk("zero_const_mvx", int'($signed(best_mvx)), 1);
        chk("zero_const_mvy", int'($signed(best_mvy)), -2);

        // Ignored start/sad_valid in IDLE, start cycle, SEARCH, DONE.
        for (int k = 0; k < 25; k++) vals[k] = 100 - k;
        run_search(1'b0, 1'b1);
        chk("junk_const_sad", int'(best_sad), 76);

        // Abort after 10 candidates with an asynchronous reset pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sad_valid = 1'b1;
            sad       = 12'd1;
            tick();
        end
        sad_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_best_sad", int'(best_sad), 12'hFFF);
        chk("abort_mvx", int'(best_mvx), 0);
        chk("abort_mvy", int'(best_mvy), 0);
        chk("abort_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("abort_no_done_busy", int'(busy), 0);
        for (int k = 0; k < 25; k++) vals[k] = (k == 17) ? 9 : 60;
        run_search(1'b1, 1'b0);

        // Default SR=7: 225 candidates, minimum at k=150 -> (-7,+3).
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        for (int k = 0; k < 225; k++) begin
            sad_valid7 = 1'b1;
            sad7       = (k == 150) ? 12'd3 : 12'd500;
            if (k == 224) begin
                e.sad = 3;
                e.x   = -7;
                e.y   = 3;
                e.cyc = cyc + 1;
                q7.push_back(e);
            end
            if (k == 100) chk("sr7_busy_mid", int'(busy7), 1);
            tick();
        end
        sad_valid7 = 1'b0;
        repeat (5) tick();

        chk("sr2_queue_drained", q2.size(), 0);
        chk("sr7_queue_drained", q7.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/sad_min_tracker.md
SAD_MIN_TRACKER -- requirements
Module: sad_min_tracker

Interface
REQ-001 Parameter SR, default 7: search range; candidate offsets run -SR..+SR per axis, so there are (2*SR+1)^2 candidates.
REQ-002 Parameter MV_W, default 5: signed motion-vector component width; it SHALL satisfy 2^(MV_W-1) > SR.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a new search.
REQ-006 sad_valid  input  1  a candidate SAD is present on sad this cycle.
REQ-007 sad  input  12  unsigned 4x4-block SAD from the upstream PE.
REQ-008 busy  output  1  high while a search is in progress.
REQ-009 done  output  1  one-cycle pulse when a search result is published.
REQ-010 best_sad  output  12  minimum SAD of the last completed search.
REQ-011 best_mvx  output  MV_W  signed x offset of the best candidate.
REQ-012 best_mvy  output  MV_W  signed y offset of the best candidate.

Function
REQ-013 FSM states SHALL be IDLE, SEARCH and DONE.
- IDLE->SEARCH on start.
- SEARCH->DONE on acceptance of the last candidate.
- DONE->IDLE unconditionally after one cycle.
REQ-014 start SHALL be ignored in SEARCH and DONE; sad_valid SHALL be ignored in IDLE and DONE, including the cycle in which start is sampled.
REQ-015 Candidates SHALL be accepted in SEARCH only, in raster order: x from -SR to +SR fastest, then y from -SR to +SR.
REQ-016 On start, the x and y position counters SHALL load -SR.
- x SHALL wrap to -SR and y SHALL increment when x=+SR is accepted.
REQ-017 The first accepted candidate SHALL load the running minimum unconditionally.
- Each later candidate SHALL replace it only if sad < running minimum (strict unsigned compare), so ties keep the earliest candidate in raster order.
REQ-018 The running minimum SHALL record sad together with the x/y counter values in the same cycle the candidate is accepted.
REQ-019 Publication:
- If the last candidate is accepted in cycle N, then in cycle N+1 done=1, busy=0, and best_sad/best_mvx/best_mvy hold the final result.
- The published outputs SHALL hold until the next done.
REQ-020 busy SHALL be 1 from the cycle after start is sampled until the cycle done is asserted, exclusive of that cycle.
REQ-021 sad gaps (sad_valid=0) in SEARCH SHALL stall the counters and the running minimum without limit.

Reset
REQ-022 On rst_n=0, regardless of clk:
- state=IDLE, busy=0, done=0, best_sad=12'hFFF, best_mvx=0, best_mvy=0, and the counters and running minimum are cleared.
REQ-023 Reset asserted mid-search SHALL abandon the search; no done SHALL follow.

Configuration
REQ-024 Macro SAD_EARLY_TERM_EN:
- When defined, an accepted candidate with sad=0 SHALL end the search immediately: done in the next cycle with that candidate as the result, and the remaining positions are not awaited.
- When undefined, every candidate SHALL be processed and a zero SAD is treated like any other value.

Structure
REQ-025 Package fsbm_pkg SHALL hold SAD_W=12, the state enum (IDLE/SEARCH/DONE), and the signed MV typedef; both sad_min_tracker and the PE stage import SAD_W from it.
REQ-026 Sub-module sad_pos_counter SHALL implement the raster x/y counters and provide a last-position flag.

Verification (SR=2 unless noted, 25 candidates)
REQ-027 Feed sad = 100-k for k=0..24 -> done 1 cycle after the 25th accept; best_sad=76, mv=(+2,+2).
REQ-028 All 25 candidates sad=50 -> best_sad=50, mv=(-2,-2), confirming first-wins on ties.
REQ-029 Single 7 at candidate 12, all others 200, with random sad_valid gaps -> best_sad=7, mv=(0,0); busy stays high across the gaps.
REQ-030 Pulse rst_n low after 10 candidates, then start a fresh search -> no done from the aborted search; the new result is correct; outputs read 12'hFFF/0/0 immediately after reset.
REQ-031 sad=0 at candidate 3 -> with SAD_EARLY_TERM_EN: done the next cycle with mv=(+1,-2); without it: done after candidate 25 with the same result.
REQ-032 start and sad_valid pulsed during SEARCH and DONE, and sad_valid pulsed in IDLE -> no state or count change; default SR=7 -> done after exactly 225 accepts.
